// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the pixel LFSR generator: regenerates the expected
// sequence from the armed seed, counts mismatches and reports pass/fail.
module lfsr_stream_checker #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] stop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_vld_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic              aborted_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic [DATA_W-1:0] first_err_data_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   exp_q;
  logic [DATA_W-1:0]   stop_q;
  logic [IDLE_W-1:0]   idle_q;

  logic [DATA_W-1:0]   exp_nxt_c;
  logic                mismatch_c;
  logic [CNT_W-1:0]    word_inc_c;
  logic [CNT_W-1:0]    err_inc_c;
  logic [CNT_W-1:0]    err_next_c;
  logic [IDLE_W-1:0]   idle_inc_c;
  logic                idle_hit_c;

  // Generator rule: shift left, feed back XNOR of bits 12 and 3.
  assign exp_nxt_c  = {exp_q[DATA_W-2:0], ~(exp_q[12] ^ exp_q[3])};
  assign mismatch_c = (data_i != exp_nxt_c);

  // Saturating counter increments.
  assign word_inc_c = (word_cnt_o == {CNT_W{1'b1}}) ? word_cnt_o : word_cnt_o + CNT_W'(1);
  assign err_inc_c  = (err_cnt_o  == {CNT_W{1'b1}}) ? err_cnt_o  : err_cnt_o  + CNT_W'(1);
  assign err_next_c = mismatch_c ? err_inc_c : err_cnt_o;

  assign idle_inc_c = idle_q + IDLE_W'(1);
  assign idle_hit_c = (idle_inc_c == IDLE_W'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      exp_q            <= '0;
      stop_q           <= '0;
      idle_q           <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      aborted_o        <= 1'b0;
      word_cnt_o       <= '0;
      err_cnt_o        <= '0;
      first_err_idx_o  <= '0;
      first_err_data_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            exp_q            <= seed_i;
            stop_q           <= stop_i;
            idle_q           <= '0;
            timeout_o        <= 1'b0;
            aborted_o        <= 1'b0;
            word_cnt_o       <= '0;
            err_cnt_o        <= '0;
            first_err_idx_o  <= '0;
            first_err_data_o <= '0;
            if (seed_i == stop_i) begin
              state_q <= ST_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              pass_o  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_o  <= 1'b1;
              done_o  <= 1'b0;
              pass_o  <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (abort_i) begin
            // Abort wins over a word arriving in the same cycle.
            aborted_o <= 1'b1;
            state_q   <= ST_DONE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
          end else if (data_vld_i) begin
            exp_q      <= exp_nxt_c;
            word_cnt_o <= word_inc_c;
            idle_q     <= '0;
            if (mismatch_c) begin
              err_cnt_o <= err_inc_c;
              if (err_cnt_o == '0) begin
                first_err_idx_o  <= word_cnt_o;
                first_err_data_o <= data_i;
              end
            end
            if (exp_nxt_c == stop_q) begin
              state_q <= ST_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              pass_o  <= (err_next_c == '0);
            end
          end else begin
            idle_q <= idle_inc_c;
            if (idle_hit_c) begin
              timeout_o <= 1'b1;
              state_q   <= ST_DONE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              pass_o    <= 1'b0;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: directed cases with literal expectations plus
// randomized traffic checked every cycle against a sequence-index model.
module tb_lfsr_stream_checker;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] seed = '0;
  logic [DW-1:0] stop = '0;
  logic [DW-1:0] data = '0;
  logic          vld = 1'b0;

  logic          busy_o, done_o, pass_o, timeout_o, aborted_o;
  logic [CW-1:0] word_cnt_o, err_cnt_o, first_err_idx_o;
  logic [DW-1:0] first_err_data_o;

  always #5 clk = ~clk;

  lfsr_stream_checker #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .abort_i         (abort),
    .seed_i          (seed),
    .stop_i          (stop),
    .data_i          (data),
    .data_vld_i      (vld),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .timeout_o       (timeout_o),
    .aborted_o       (aborted_o),
    .word_cnt_o      (word_cnt_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_idx_o (first_err_idx_o),
    .first_err_data_o(first_err_data_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: a run is "the n-th word of the sequence from seed"; phase is abstract.
  typedef enum {M_IDLE, M_RUN, M_DONE} phase_t;
  phase_t        m_ph = M_IDLE;
  logic [DW-1:0] m_seed = '0, m_stop = '0, m_fd = '0;
  int            m_k = 0, m_wc = 0, m_ec = 0, m_fi = 0, m_idle = 0;
  bit            m_busy = 0, m_done = 0, m_pass = 0, m_to = 0, m_ab = 0;

  // n applications of the generator rule starting from s.
  function automatic logic [DW-1:0] nth(input logic [DW-1:0] s, input int n);
    logic [DW-1:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = {x[DW-2:0], ~(x[12] ^ x[3])};
    return x;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic finish_run(input bit p);
    m_ph = M_DONE; m_busy = 0; m_done = 1; m_pass = p;
  endtask

  task automatic model_update();
    logic [DW-1:0] e;
    if (reset) begin
      m_ph = M_IDLE; m_seed = '0; m_stop = '0; m_fd = '0;
      m_k = 0; m_wc = 0; m_ec = 0; m_fi = 0; m_idle = 0;
      m_busy = 0; m_done = 0; m_pass = 0; m_to = 0; m_ab = 0;
    end else if (m_ph != M_RUN) begin
      if (start) begin
        m_seed = seed; m_stop = stop; m_k = 0; m_wc = 0; m_ec = 0;
        m_fi = 0; m_fd = '0; m_idle = 0; m_to = 0; m_ab = 0;
        if (seed == stop) finish_run(1);
        else begin m_ph = M_RUN; m_busy = 1; m_done = 0; m_pass = 0; end
      end
    end else if (abort) begin
      m_ab = 1;
      finish_run(0);
    end else if (vld) begin
      e = nth(m_seed, m_k + 1);
      m_k++;
      if (data !== e) begin
        if (m_ec == 0) begin m_fi = m_wc; m_fd = data; end
        m_ec = sat(m_ec + 1);
      end
      m_wc = sat(m_wc + 1);
      m_idle = 0;
      if (e == m_stop) finish_run(m_ec == 0);
    end else begin
      m_idle++;
      if (m_idle == int'(TO)) begin m_to = 1; finish_run(0); end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("busy_o", 32'(busy_o), 32'(m_busy));
    check("done_o", 32'(done_o), 32'(m_done));
    check("pass_o", 32'(pass_o), 32'(m_pass));
    check("timeout_o", 32'(timeout_o), 32'(m_to));
    check("aborted_o", 32'(aborted_o), 32'(m_ab));
    check("word_cnt_o", 32'(word_cnt_o), 32'(m_wc));
    check("err_cnt_o", 32'(err_cnt_o), 32'(m_ec));
    check("first_err_idx_o", 32'(first_err_idx_o), 32'(m_fi));
    check("first_err_data_o", 32'(first_err_data_o), 32'(m_fd));
  endtask

  // One clock: inputs already driven, model follows the edge, outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    reset = 0; start = 0; abort = 0; vld = 0;
  endtask

  task automatic arm(input logic [DW-1:0] sd, input logic [DW-1:0] sp);
    seed = sd; stop = sp; start = 1; step();
  endtask

  task automatic word(input logic [DW-1:0] d);
    data = d; vld = 1; step();
  endtask

  task automatic idle_cycle();
    step();
  endtask

  initial begin
    // Reset state
    reset = 1; step();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_word_cnt", 32'(word_cnt_o), 0);

    // Clean run
    arm(16'h0001, 16'h001E);
    check("clean_busy", 32'(busy_o), 1);
    word(16'h0003); word(16'h0007); word(16'h000F);
    check("clean_not_done", 32'(done_o), 0);
    word(16'h001E);
    check("clean_done", 32'(done_o), 1);
    check("clean_pass", 32'(pass_o), 1);
    check("clean_word_cnt", 32'(word_cnt_o), 4);
    check("clean_err_cnt", 32'(err_cnt_o), 0);

    // Corrupted second word, re-armed from DONE
    arm(16'h0001, 16'h001E);
    word(16'h0003); word(16'h0006); word(16'h000F); word(16'h001E);
    check("corr_done", 32'(done_o), 1);
    check("corr_pass", 32'(pass_o), 0);
    check("corr_err_cnt", 32'(err_cnt_o), 1);
    check("corr_first_idx", 32'(first_err_idx_o), 1);
    check("corr_first_data", 32'(first_err_data_o), 32'h0006);

    // Seed equals stop
    arm(16'h1234, 16'h1234);
    check("eq_done", 32'(done_o), 1);
    check("eq_busy", 32'(busy_o), 0);
    check("eq_pass", 32'(pass_o), 1);
    check("eq_word_cnt", 32'(word_cnt_o), 0);

    // Timeout after two good words
    arm(16'h0001, 16'h001E);
    word(16'h0003); word(16'h0007);
    for (int i = 0; i < 7; i++) idle_cycle();
    check("to_not_yet", 32'(done_o), 0);
    idle_cycle();
    check("to_timeout", 32'(timeout_o), 1);
    check("to_done", 32'(done_o), 1);
    check("to_pass", 32'(pass_o), 0);
    check("to_word_cnt", 32'(word_cnt_o), 2);

    // Abort collides with a data word
    arm(16'h0001, 16'h001E);
    word(16'h0003);
    abort = 1; data = 16'h0007; vld = 1; step();
    check("ab_aborted", 32'(aborted_o), 1);
    check("ab_done", 32'(done_o), 1);
    check("ab_pass", 32'(pass_o), 0);
    check("ab_word_cnt", 32'(word_cnt_o), 1);
    abort = 1; step();
    check("ab_in_done_ignored", 32'(aborted_o), 1);

    // Reset mid-run, then a fresh clean run
    arm(16'h0001, 16'h001E);
    word(16'h0003); word(16'h0007);
    reset = 1; step();
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_word_cnt", 32'(word_cnt_o), 0);
    arm(16'h0001, 16'h001E);
    word(16'h0003); word(16'h0007); word(16'h000F); word(16'h001E);
    check("rerun_pass", 32'(pass_o), 1);
    check("rerun_word_cnt", 32'(word_cnt_o), 4);

    // Randomized traffic against the model
    begin
      int gap = 0;
      for (int c = 0; c < 3000; c++) begin
        reset = ($urandom_range(0, 299) == 0);
        if (m_ph != M_RUN) start = ($urandom_range(0, 3) == 0);
        else start = ($urandom_range(0, 49) == 0);
        seed = ($urandom_range(0, 15) == 0) ? 16'hFFFF : DW'($urandom);
        stop = ($urandom_range(0, 7) == 0) ? DW'($urandom)
                                           : nth(seed, int'($urandom_range(0, 24)));
        abort = ($urandom_range(0, 99) == 0);
        if (gap > 0) begin
          vld = 0; gap--;
        end else if ($urandom_range(0, 39) == 0) begin
          vld = 0; gap = int'($urandom_range(0, 10));
        end else begin
          vld = ($urandom_range(0, 9) < 8);
        end
        if (m_ph == M_RUN) begin
          data = nth(m_seed, m_k + 1);
          if ($urandom_range(0, 11) == 0) data = data ^ DW'(1 << $urandom_range(0, DW - 1));
        end else begin
          data = DW'($urandom);
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side checker for the pixel LFSR generator. It is armed with the same seed and stop values loaded into the generator, then consumes the generator's output stream (the data word plus its ready strobe). It regenerates the expected sequence internally and counts mismatches. It reports pass/fail when the expected stop word is reached, on a timeout, or on an abort. It sits in the self-test path next to the generator and feeds the status/readback logic.

## Interface
- DATA_W, 16, stream word width; must be ≥ 13 (feedback taps fixed at bits 12 and 3)
- CNT_W, 16, width of word and error counters
- TIMEOUT, 1024, max idle cycles in RUN without a valid word; must be ≥ 1

- clk_i  in  1  clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  arm pulse; samples seed_i/stop_i
- abort_i  in  1  force end of check
- seed_i  in  DATA_W  seed value loaded into the generator
- stop_i  in  DATA_W  stop value loaded into the generator
- data_i  in  DATA_W  generator output word
- data_vld_i  in  1  generator ready strobe; data_i valid this cycle
- busy_o  out  1  high in RUN
- done_o  out  1  high in DONE
- pass_o  out  1  valid while done_o: err_cnt_o==0, no timeout, no abort
- timeout_o  out  1  sticky; DONE was reached by timeout
- aborted_o  out  1  sticky; DONE was reached by abort
- word_cnt_o  out  CNT_W  accepted words, saturating
- err_cnt_o  out  CNT_W  mismatched words, saturating
- first_err_idx_o  out  CNT_W  word index (0-based) of first mismatch
- first_err_data_o  out  DATA_W  data_i at first mismatch

## Operation
- Next-state function nxt(x) = {x[DATA_W-2:0], x[12] XNOR x[3]}. This is the generator's rule.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start_i: exp ← seed_i, stop ← stop_i; clear counters, timeout counter and flags.
  - Go to DONE if seed_i == stop_i; otherwise go to RUN.
  - data_vld_i is ignored.
- RUN, for each data_vld_i cycle:
  - Compare data_i with nxt(exp). On mismatch, increment err_cnt. If err_cnt was 0, capture first_err_idx = word_cnt and first_err_data = data_i.
  - exp ← nxt(exp) always. Tracking is free-running and never resyncs to data_i.
  - word_cnt increments; idle counter clears.
  - If nxt(exp) == stop, go to DONE.
- RUN, cycle without data_vld_i: idle counter increments. When it reaches TIMEOUT, set timeout_o and go to DONE.
- abort_i in RUN: set aborted_o and go to DONE. abort_i has priority over a data word in the same cycle; that word is not counted.
- DONE: all results hold. start_i re-arms exactly as in IDLE. abort_i is ignored. data_vld_i is ignored.
- start_i in RUN is ignored.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- All-ones seed is the XNOR lock-up state. Expected words stay all-ones. No special handling: the run ends by stop match, timeout or abort.

## Timing
- All outputs are registered.
- Reset values: busy_o, done_o, pass_o, timeout_o and aborted_o are 0; all counters and captures are 0; state is IDLE.
- busy_o goes high the cycle after start_i.
- Counters and captures update the cycle after the accepted word.
- done_o and pass_o become valid the cycle after the terminating word, timeout or abort. Both are high simultaneously with the final counter values.
- seed == stop: done_o is high the cycle after start_i with word_cnt 0 and pass_o 1.
- reset_i has priority over every input. Asserting it mid-RUN returns to IDLE with reset values on the next edge.
- Throughput is one word per cycle. data_vld_i may be high continuously.

## Test plan
- Clean run: seed 0x0001, stop 0x001E, stream 0x0003, 0x0007, 0x000F, 0x001E on back-to-back cycles -> done_o one cycle after the last word, pass_o=1, word_cnt=4, err_cnt=0.
- Corrupted word: same setup, second word 0x0006 -> err_cnt=1, first_err_idx=1, first_err_data=0x0006; done after 4 words, pass_o=0.
- Seed equals stop: seed=stop=0x1234 -> done_o the cycle after start_i, word_cnt=0, pass_o=1, busy_o never high.
- Timeout: TIMEOUT=8, start, two good words, then 8 idle cycles -> timeout_o=1, done_o=1, pass_o=0, word_cnt=2.
- Abort vs data: abort_i and data_vld_i in the same RUN cycle -> aborted_o=1, word not counted, pass_o=0.
- Reset mid-run: reset_i after 2 words -> next cycle all outputs 0, state IDLE. A new start_i then runs the clean-run case correctly.
